// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state enum and control encodings shared by cpu_ctrl_fsm.
// Branch-only states/constants exist when CPU_CTRL_BRANCH_EN is defined.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
        S_MOV_IMM, S_MOV_B, S_MOV_C, S_MOV_W,
        S_GET_A, S_GET_B, S_ALU, S_WRITE_REG,
        S_MEM_A, S_MEM_ADD, S_MEM_ADDR, S_LDR_RD, S_LDR_WR,
        S_STR_B, S_STR_C, S_STR_WR,
        S_HALT, S_FAULT
`ifdef CPU_CTRL_BRANCH_EN
        , S_BR, S_BR_T, S_LINK, S_BX_B, S_BX_C, S_BX_PC
`endif
    } state_t;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    localparam logic [1:0] PC_INC = 2'b00;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b00;

`ifdef CPU_CTRL_BRANCH_EN
    localparam logic [3:0] VSEL_PC = 4'b0010;

    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [2:0] OPC_BR = 3'b001;
    localparam logic [2:0] OPC_BL = 3'b010;

    localparam logic [1:0] OP_BR  = 2'b00;
    localparam logic [1:0] OP_BL  = 2'b11;
    localparam logic [1:0] OP_BX  = 2'b00;
    localparam logic [1:0] OP_BLX = 2'b10;

    localparam logic [2:0] CC_AL = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_NE = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_LE = 3'b100;

    // Returns {valid, taken}; unknown codes are invalid.
    function automatic logic [1:0] cond_eval(
        input logic [2:0] cc,
        input logic       z,
        input logic       n,
        input logic       v
    );
        logic [1:0] r;
        r = 2'b00;
        unique case (cc)
            CC_AL:   r = 2'b11;
            CC_EQ:   r = {1'b1, z};
            CC_NE:   r = {1'b1, !z};
            CC_LT:   r = {1'b1, n ^ v};
            CC_LE:   r = {1'b1, (n ^ v) | z};
            default: r = 2'b00;
        endcase
        return r;
    endfunction
`endif

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent in a memory wait state with mem_ready low.
// Ports: clk, reset (async, active-low), in_wait, mem_ready -> timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic mem_ready,
    output logic timeout
);

    localparam int CW = (WAIT_W < 1) ? 1 : WAIT_W;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] count;

    // Any exit from the wait state (ready, timeout, not waiting) clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!in_wait || mem_ready) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // A ready in the limit cycle still wins over the timeout.
    assign timeout = (MEM_TIMEOUT != 0) && in_wait
                     && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: Moore controller for the 16-bit CPU (fetch/decode/exec).
// In: clk, reset(n), opcode, op, cond, Z/N/V, mem_ready. Out: datapath,
// PC, fetch, mem_cmd, halted, mem_err. Branches need CPU_CTRL_BRANCH_EN.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       mem_ready,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       load_pc,
    output logic       reset_pc,
    output logic [1:0] pc_sel,
    output logic       load_ir,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic       mem_err
);

    state_t state;
    state_t next;
    state_t decode_next;
    logic   in_wait;
    logic   timeout;
    // Remembers which branch a shared sequence takes after DECODE:
    // STR vs LDR after MEM_ADDR, BLX vs BL after LINK.
    logic   sub_path;

    assign in_wait = (state == S_IF1) || (state == S_LDR_RD)
                     || (state == S_STR_WR);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .WAIT_W     (WAIT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .in_wait  (in_wait),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RST;
            sub_path <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE) begin
`ifdef CPU_CTRL_BRANCH_EN
                sub_path <= (opcode == OPC_STR) || (op == OP_BLX);
`else
                sub_path <= (opcode == OPC_STR);
`endif
            end
        end
    end

`ifdef CPU_CTRL_BRANCH_EN
    logic [1:0] cc;
    assign cc = cond_eval(cond, Z, N, V);
`else
    logic unused_flags;
    assign unused_flags = ^{cond, Z, N, V};
`endif

    always_comb begin
        decode_next = S_FAULT;
        unique case (1'b1)
            opcode == OPC_MOV && op == OP_MOV_IMM:
                decode_next = S_MOV_IMM;
            opcode == OPC_MOV && op == OP_MOV_REG:
                decode_next = S_MOV_B;
            opcode == OPC_ALU:
                decode_next = S_GET_A;
            (opcode == OPC_LDR || opcode == OPC_STR) && op == OP_MEM:
                decode_next = S_MEM_A;
            opcode == OPC_HALT:
                decode_next = S_HALT;
`ifdef CPU_CTRL_BRANCH_EN
            opcode == OPC_BR && op == OP_BR:
                decode_next = !cc[1] ? S_FAULT
                              : (cc[0] ? S_BR_T : S_BR);
            opcode == OPC_BL && op == OP_BL:
                decode_next = S_LINK;
            opcode == OPC_BL && op == OP_BX:
                decode_next = S_BX_B;
            opcode == OPC_BL && op == OP_BLX:
                decode_next = S_LINK;
`endif
            default:
                decode_next = S_FAULT;
        endcase
    end

    always_comb begin
        next = state;
        unique case (state)
            S_RST:       next = S_IF1;
            S_IF1: begin
                if (timeout)        next = S_FAULT;
                else if (mem_ready) next = S_IF2;
            end
            S_IF2:       next = S_UPDATE_PC;
            S_UPDATE_PC: next = S_DECODE;
            S_DECODE:    next = decode_next;
            S_MOV_IMM:   next = S_IF1;
            S_MOV_B:     next = S_MOV_C;
            S_MOV_C:     next = S_MOV_W;
            S_MOV_W:     next = S_IF1;
            S_GET_A:     next = S_GET_B;
            S_GET_B:     next = S_ALU;
            S_ALU:       next = S_WRITE_REG;
            S_WRITE_REG: next = S_IF1;
            S_MEM_A:     next = S_MEM_ADD;
            S_MEM_ADD:   next = S_MEM_ADDR;
            S_MEM_ADDR:  next = sub_path ? S_STR_B : S_LDR_RD;
            S_LDR_RD: begin
                if (timeout)        next = S_FAULT;
                else if (mem_ready) next = S_LDR_WR;
            end
            S_LDR_WR:    next = S_IF1;
            S_STR_B:     next = S_STR_C;
            S_STR_C:     next = S_STR_WR;
            S_STR_WR: begin
                if (timeout)        next = S_FAULT;
                else if (mem_ready) next = S_IF1;
            end
            S_HALT:      next = S_HALT;
            S_FAULT:     next = S_FAULT;
`ifdef CPU_CTRL_BRANCH_EN
            S_BR:        next = S_IF1;
            S_BR_T:      next = S_IF1;
            S_LINK:      next = sub_path ? S_BX_B : S_BR_T;
            S_BX_B:      next = S_BX_C;
            S_BX_C:      next = S_BX_PC;
            S_BX_PC:     next = S_IF1;
`endif
            default:     next = S_FAULT;
        endcase
    end

    always_comb begin
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        write     = 1'b0;
        nsel      = NSEL_NONE;
        vsel      = VSEL_NONE;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        pc_sel    = PC_INC;
        load_ir   = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MNONE;
        halted    = 1'b0;
        mem_err   = 1'b0;
        unique case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
                load_ir  = 1'b1;
            end
            S_UPDATE_PC: load_pc = 1'b1;
            S_MOV_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            S_MOV_B, S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_MOV_C, S_STR_C: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MOV_W, S_WRITE_REG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            S_GET_A, S_MEM_A: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_ALU: begin
                loadc = 1'b1;
                loads = 1'b1;
            end
            S_MEM_ADD: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEM_ADDR: load_addr = 1'b1;
            S_LDR_RD:   mem_cmd = MREAD;
            S_LDR_WR: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_MDATA;
                write = 1'b1;
            end
            S_STR_B: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_STR_WR: mem_cmd = MWRITE;
            S_HALT:   halted  = 1'b1;
            S_FAULT:  mem_err = 1'b1;
`ifdef CPU_CTRL_BRANCH_EN
            S_BR_T: begin
                load_pc = 1'b1;
                pc_sel  = PC_REL;
            end
            S_LINK: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_PC;
                write = 1'b1;
            end
            S_BX_B: begin
                nsel  = NSEL_RD;
                loadb = 1'b1;
            end
            S_BX_C: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_BX_PC: begin
                load_pc = 1'b1;
                pc_sel  = PC_REG;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Parametrised successor to the CPU controller state machine. Sequences fetch, decode, ALU, MOV, LDR/STR and HALT for the 16-bit datapath, plus conditional branch and call/return instructions. Every memory access waits on a `mem_ready` handshake, with a configurable timeout into a sticky FAULT state. Sits between the instruction register decoder and the datapath/PC/memory-address logic.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles with `mem_ready` low before FAULT; 0 disables the timeout.
- `WAIT_W`, default `$clog2(MEM_TIMEOUT+1)`: wait counter width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `opcode` input 3: IR[15:13].
- `op` input 2: IR[12:11].
- `cond` input 3: IR[10:8], branch condition.
- `Z`, `N`, `V` input 1 each: status flags from the datapath status register.
- `mem_ready` input 1: memory has completed the current `mem_cmd`.
- `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `write` output 1 each: datapath controls.
- `nsel` output 3: one-hot register select; 100 = Rn, 010 = Rd, 001 = Rm.
- `vsel` output 4: one-hot writeback select; 1000 = mdata, 0100 = sximm8, 0010 = PC, 0001 = C.
- `load_pc`, `reset_pc` output 1 each: PC register controls.
- `pc_sel` output 2: next PC; 00 = PC+1, 01 = PC+1+sximm8, 10 = C.
- `load_ir`, `addr_sel`, `load_addr` output 1 each: fetch and data-address controls.
- `mem_cmd` output 2: 00 = MNONE, 01 = MREAD, 10 = MWRITE.
- `halted` output 1: the FSM is in HALT.
- `mem_err` output 1: the FSM is in FAULT.

## Operation
- Moore machine: all outputs decode from the registered state only. Every output defaults to 0 and `mem_cmd` defaults to MNONE in every state.
- **Fetch:**
  - RST→IF1. RST drives `reset_pc`=`load_pc`=1.
  - IF1 drives `addr_sel`=1 and MREAD. It holds until `mem_ready`=1, then →IF2.
  - IF2 drives `addr_sel`=1, MREAD and `load_ir`=1, then →UPDATE_PC.
  - UPDATE_PC drives `load_pc`=1 with `pc_sel`=00, then →DECODE.
- **Decode on {opcode, op}:**
  - 110_10 → MOV_IMM.
  - 110_00 → MOV_B→MOV_C→MOV_W.
  - 101_xx → GET_A→GET_B→ALU→WRITE_REG.
  - 011_00 → LDR.
  - 100_00 → STR.
  - 111_xx → HALT.
  - 001_00 → BR.
  - 010_11 → BL.
  - 010_00 → BX.
  - 010_10 → BLX.
  - Any other encoding → FAULT.
- **ALU and MOV:** GET_A and GET_B are followed by ALU, which drives `loadc`=`loads`=1. WRITE_REG writes Rd with `vsel`=C.
- **LDR:**
  - MEM_A loads A from Rn. MEM_ADD drives `bsel`=1 and `loadc`=1.
  - MEM_ADDR drives `load_addr`=1.
  - LDR_RD drives MREAD and waits on `mem_ready`.
  - LDR_WR drives `nsel`=Rd, `vsel`=mdata, `write`=1.
- **STR:**
  - MEM_A, MEM_ADD and MEM_ADDR as for LDR.
  - STR_B loads B from Rd. STR_C drives `asel`=1 and `loadc`=1.
  - STR_WR drives MWRITE and waits on `mem_ready`.
- **BR:** taken when `cond` evaluates true.
  - 000 always; 001 Z; 010 !Z; 011 N≠V; 100 (N≠V)|Z; other values → FAULT.
  - Taken: `load_pc`=1, `pc_sel`=01.
  - Not taken: no PC write.
  - →IF1 in both cases.
- **BL:** LINK writes R7 (`nsel`=Rn, `vsel`=PC, `write`=1), then BR_T loads PC with `pc_sel`=01.
- **BX:** BX_B loads B from Rd. BX_C drives `asel`=1 and `loadc`=1. BX_PC drives `load_pc`=1, `pc_sel`=10.
- **BLX:** LINK, then the BX sequence.
- **HALT and FAULT:** both are absorbing until `reset` asserts. FAULT asserts `mem_err`=1.

## Timing
- Reset asynchronously forces RST. Reset values:
  - `reset_pc`=1, `load_pc`=1.
  - Every other output 0; `nsel`=000, `vsel`=0000, `pc_sel`=00, `mem_cmd`=MNONE.
  - Wait counter 0.
- Reset asserted mid-access drops `mem_cmd` to MNONE immediately (asynchronously).
- The first fetch address is presented in the first cycle after `reset` deasserts plus one clock (RST→IF1).
- **Wait-state latency:** a wait state with `mem_ready` already high at its first edge lasts 1 cycle. Each cycle `mem_ready` stays low adds 1 cycle.
- **Timeout:**
  - The wait counter increments each cycle spent in a wait state with `mem_ready`=0.
  - When the count equals `MEM_TIMEOUT` and `mem_ready` is still 0, the next state is FAULT.
  - `mem_ready`=1 in that same cycle wins: normal transition, no fault.
  - The counter clears on every exit from a wait state.
- **Instruction latency** (zero wait states, from DECODE):
  - ALU: 5 cycles to IF1.
  - MOV_IMM: 2.
  - LDR: 6.
  - STR: 7.
  - BR: 2.
  - BL: 3.
  - BX: 4.
  - BLX: 5.
- `mem_ready` is ignored outside the wait states IF1, LDR_RD and STR_WR.

## Configuration
- `CPU_CTRL_BRANCH_EN` defined: the BR, BL, BX and BLX states and `pc_sel` values 01/10 are present.
- Not defined:
  - opcodes 001 and 010 decode to FAULT;
  - `pc_sel` is tied to 00;
  - no branch or link states are synthesised.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - MNONE/MREAD/MWRITE;
  - `nsel`, `vsel` and `pc_sel` encodings;
  - opcode/op constants;
  - the condition code constants.
- Sub-module `mem_wait_timer` (parameter `MEM_TIMEOUT`):
  - inputs `clk`, `reset`, `in_wait`, `mem_ready`;
  - output `timeout`;
  - owns the wait counter.

## Test plan
- Reset mid-fetch: assert `reset` while in IF1 with MREAD → `mem_cmd`=00, `reset_pc`=1 asynchronously. After release: RST, then IF1.
- ADD R2,R1,R0 with `mem_ready` tied high → state sequence DECODE, GET_A, GET_B, ALU, WRITE_REG, IF1. `write`=1 with `vsel`=0001 and `nsel`=010 only in WRITE_REG.
- LDR with `mem_ready` held low for 3 cycles in LDR_RD → LDR_RD lasts 4 cycles. LDR_WR drives `vsel`=1000, `write`=1.
- `MEM_TIMEOUT`=4, `mem_ready` never rises in IF1 → FAULT after the 5th IF1 cycle; `mem_err`=1 is held.
- BEQ (`cond`=001) with Z=1 → `load_pc`=1, `pc_sel`=01. With Z=0 → `load_pc`=0, then IF1.
- Without `CPU_CTRL_BRANCH_EN`, decode {001,00} → FAULT, `pc_sel`=00. With the macro, BLX → LINK (`vsel`=0010, `nsel`=100) then BX_PC (`pc_sel`=10).
